// File: rtl/vid_timing_pkg.sv
// vid_timing_pkg
//   Shared raster-timing definitions for the video chain: default 640x480@60
//   constants, the HV trigger bus layout, and the pixel-phase step helper.
//   The text/OSD generators and the GPU RAM use the same trigger indices.
package vid_timing_pkg;

   localparam int DEF_H_RES       = 640;
   localparam int DEF_H_FP        = 16;
   localparam int DEF_H_SYNC      = 96;
   localparam int DEF_H_BP        = 48;
   localparam int DEF_V_RES       = 480;
   localparam int DEF_V_FP        = 10;
   localparam int DEF_V_SYNC      = 2;
   localparam int DEF_V_BP        = 33;
   localparam int DEF_PIX_CLK_DIV = 4;

   localparam int CNT_W     = 12;
   localparam int CNT_MAX   = 4096;
   localparam int HV_TRIG_W = 48;

   localparam int HV_TRIG_LINE_START  = 24;
   localparam int HV_TRIG_FRAME_START = 25;
   localparam int HV_TRIG_VDE_FALL    = 26;

   typedef logic [CNT_W-1:0] cnt_t;

   // Bit layout matches the HV_TRIG_* indices above.
   typedef struct packed {
      logic [20:0] rsvd;
      logic        vde_fall;
      logic        frame_start;
      logic        line_start;
      cnt_t        v;
      cnt_t        h;
   } hv_trig_t;

   // Next pixel phase; a divider of 1 keeps the phase at 0.
   function automatic logic [3:0] next_phase(input logic [3:0] ph, input int div);
      if (div <= 1 || ph == 4'(div - 1))
         return 4'd0;
      return ph + 4'd1;
   endfunction

endpackage

// File: rtl/vid_sync_generator_if.sv
// vid_sync_generator_if
//   Raster timing bundle driven by vid_sync_generator.
//   pc_ena          : pixel phase, pixel logic acts when 0
//   hde_out/vde_out : display enables
//   hs_out/vs_out   : sync pulses (polarity set by the generator)
//   h_count/v_count : live pixel/line counters
//   HV_triggers_out : packed {flags, v, h} trigger bus
interface vid_sync_generator_if;
   import vid_timing_pkg::*;

   logic [3:0]           pc_ena;
   logic                 hde_out;
   logic                 vde_out;
   logic                 hs_out;
   logic                 vs_out;
   cnt_t                 h_count;
   cnt_t                 v_count;
   logic [HV_TRIG_W-1:0] HV_triggers_out;

   modport master (output pc_ena, hde_out, vde_out, hs_out, vs_out,
                   h_count, v_count, HV_triggers_out);
   modport slave  (input  pc_ena, hde_out, vde_out, hs_out, vs_out,
                   h_count, v_count, HV_triggers_out);
endinterface

// File: rtl/vid_axis_counter.sv
// vid_axis_counter
//   One raster axis: a wrapping position counter plus registered region
//   decode (active / front porch / sync / back porch).
//   clk, reset_n : clock, async active-low reset
//   tick         : advance the counter
//   dec_ena      : pixel tick; latch decode of the current count
//   count        : live counter
//   wrap_out     : counter sits at its last value (combinational)
//   de_out       : registered display enable
//   sync_out     : registered sync, active level POL
//   dec_count    : counter value the registered decode belongs to
module vid_axis_counter
   import vid_timing_pkg::*;
#(
   parameter int RES  = DEF_H_RES,
   parameter int FP   = DEF_H_FP,
   parameter int SYNC = DEF_H_SYNC,
   parameter int BP   = DEF_H_BP,
   parameter bit POL  = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic tick,
   input  logic dec_ena,
   output cnt_t count,
   output logic wrap_out,
   output logic de_out,
   output logic sync_out,
   output cnt_t dec_count
);

   localparam int   TOTAL      = RES + FP + SYNC + BP;
   localparam int   SYNC_START = RES + FP;
   localparam int   SYNC_END   = RES + FP + SYNC;
   localparam cnt_t LAST       = cnt_t'(TOTAL - 1);

   cnt_t count_p0;
   logic de_p1;
   logic sync_p1;
   cnt_t count_p1;

   assign wrap_out = (count_p0 == LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_p0 <= '0;
         de_p1    <= 1'b0;
         sync_p1  <= ~POL;
         count_p1 <= '0;
      end else begin
         if (tick)
            count_p0 <= wrap_out ? '0 : count_p0 + cnt_t'(1);
         // p0 -> p1: decode lags the counter by one pixel tick
         if (dec_ena) begin
            de_p1    <= (int'(count_p0) < RES);
            sync_p1  <= (int'(count_p0) >= SYNC_START && int'(count_p0) < SYNC_END) ? POL : ~POL;
            count_p1 <= count_p0;
         end
      end
   end

   assign count     = count_p0;
   assign de_out    = de_p1;
   assign sync_out  = sync_p1;
   assign dec_count = count_p1;

endmodule

// File: rtl/vid_sync_generator.sv
// vid_sync_generator
//   Raster timing source at the head of the video chain. Divides clk into
//   pixel phases, runs the H and V axis counters and publishes decoded
//   timing plus the HV trigger bus.
//   clk     : system clock
//   reset_n : async active-low reset
//   vid     : timing bundle (pc_ena, hde/vde/hs/vs, counters, triggers)
module vid_sync_generator
   import vid_timing_pkg::*;
#(
   parameter int H_RES       = DEF_H_RES,
   parameter int H_FP        = DEF_H_FP,
   parameter int H_SYNC      = DEF_H_SYNC,
   parameter int H_BP        = DEF_H_BP,
   parameter int V_RES       = DEF_V_RES,
   parameter int V_FP        = DEF_V_FP,
   parameter int V_SYNC      = DEF_V_SYNC,
   parameter int V_BP        = DEF_V_BP,
   parameter int PIX_CLK_DIV = DEF_PIX_CLK_DIV,
   parameter bit HS_POL      = 1'b0,
   parameter bit VS_POL      = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   vid_sync_generator_if.master vid
);

   localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_total_chk
      $error("vid_sync_generator: H_TOTAL/V_TOTAL exceed 12-bit counter range");
   end
   if (PIX_CLK_DIV < 1 || PIX_CLK_DIV > 16) begin : g_div_chk
      $error("vid_sync_generator: PIX_CLK_DIV must be 1..16");
   end

   logic [3:0] pc_p0;
   logic       pix_tick;
   cnt_t       h_cnt, v_cnt, h_dec, v_dec;
   logic       h_wrap, v_wrap_unused;
   logic       hde, vde, hs, vs;
   logic       line_start_p1, frame_start_p1, vde_fall_p1;

   assign pix_tick = (pc_p0 == 4'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_p0          <= 4'd0;
         line_start_p1  <= 1'b0;
         frame_start_p1 <= 1'b0;
         vde_fall_p1    <= 1'b0;
      end else begin
         pc_p0 <= next_phase(pc_p0, PIX_CLK_DIV);
         // p0 -> p1: trigger flags registered with the axis decodes
         if (pix_tick) begin
            line_start_p1  <= (h_cnt == '0);
            frame_start_p1 <= (h_cnt == '0) && (v_cnt == '0);
            vde_fall_p1    <= (h_cnt == '0) && (v_cnt == cnt_t'(V_RES));
         end
      end
   end

   vid_axis_counter #(
      .RES(H_RES), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)
   ) u_h (
      .clk(clk), .reset_n(reset_n), .tick(pix_tick), .dec_ena(pix_tick),
      .count(h_cnt), .wrap_out(h_wrap), .de_out(hde), .sync_out(hs),
      .dec_count(h_dec)
   );

   // Lines advance on the pixel tick that wraps the horizontal counter; the
   // vertical decode still latches every pixel tick so it stays aligned to h.
   vid_axis_counter #(
      .RES(V_RES), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)
   ) u_v (
      .clk(clk), .reset_n(reset_n), .tick(h_wrap && pix_tick), .dec_ena(pix_tick),
      .count(v_cnt), .wrap_out(v_wrap_unused), .de_out(vde), .sync_out(vs),
      .dec_count(v_dec)
   );

   hv_trig_t trig;
   always_comb begin
      trig             = '0;
      trig.h           = h_dec;
      trig.v           = v_dec;
      trig.line_start  = line_start_p1;
      trig.frame_start = frame_start_p1;
      trig.vde_fall    = vde_fall_p1;
   end

   assign vid.pc_ena          = pc_p0;
   assign vid.hde_out         = hde;
   assign vid.vde_out         = vde;
   assign vid.hs_out          = hs;
   assign vid.vs_out          = vs;
   assign vid.h_count         = h_cnt;
   assign vid.v_count         = v_cnt;
   assign vid.HV_triggers_out = trig;

endmodule

// File: tb/tb_vid_sync_generator.sv
// tb_vid_sync_generator
//   Three generator instances (default 640x480, a small raster with
//   divider 4, and a divider-1 raster with positive sync) checked against a
//   closed-form position model through per-instance expectation queues, plus
//   table-driven line timing and hand-written multi-cycle sequences.
module tb_vid_sync_generator;

   typedef struct packed {
      int   hres, hfp, hsync, hbp, vres, vfp, vsync, vbp, div;
      logic hpol, vpol;
   } cfg_t;

   typedef struct packed {
      logic [11:0] hc, vc;
      logic        hde, vde, hs, vs;
      logic [47:0] trig;
   } exp_t;

   localparam cfg_t C_DEF = '{hres:640, hfp:16, hsync:96, hbp:48, vres:480, vfp:10,
                              vsync:2, vbp:33, div:4, hpol:1'b0, vpol:1'b0};
   localparam cfg_t C_SML = '{hres:8, hfp:1, hsync:2, hbp:1, vres:6, vfp:1,
                              vsync:2, vbp:1, div:4, hpol:1'b0, vpol:1'b0};
   localparam cfg_t C_UNI = '{hres:8, hfp:1, hsync:2, hbp:1, vres:4, vfp:1,
                              vsync:1, vbp:1, div:1, hpol:1'b1, vpol:1'b1};

   logic clk = 1'b0;
   logic rst_d = 1'b0, rst_s = 1'b0, rst_u = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   vid_sync_generator_if if_d ();
   vid_sync_generator_if if_s ();
   vid_sync_generator_if if_u ();

   vid_sync_generator #(
      .H_RES(C_DEF.hres), .H_FP(C_DEF.hfp), .H_SYNC(C_DEF.hsync), .H_BP(C_DEF.hbp),
      .V_RES(C_DEF.vres), .V_FP(C_DEF.vfp), .V_SYNC(C_DEF.vsync), .V_BP(C_DEF.vbp),
      .PIX_CLK_DIV(C_DEF.div), .HS_POL(C_DEF.hpol), .VS_POL(C_DEF.vpol)
   ) u_def (.clk(clk), .reset_n(rst_d), .vid(if_d));

   vid_sync_generator #(
      .H_RES(C_SML.hres), .H_FP(C_SML.hfp), .H_SYNC(C_SML.hsync), .H_BP(C_SML.hbp),
      .V_RES(C_SML.vres), .V_FP(C_SML.vfp), .V_SYNC(C_SML.vsync), .V_BP(C_SML.vbp),
      .PIX_CLK_DIV(C_SML.div), .HS_POL(C_SML.hpol), .VS_POL(C_SML.vpol)
   ) u_sml (.clk(clk), .reset_n(rst_s), .vid(if_s));

   vid_sync_generator #(
      .H_RES(C_UNI.hres), .H_FP(C_UNI.hfp), .H_SYNC(C_UNI.hsync), .H_BP(C_UNI.hbp),
      .V_RES(C_UNI.vres), .V_FP(C_UNI.vfp), .V_SYNC(C_UNI.vsync), .V_BP(C_UNI.vbp),
      .PIX_CLK_DIV(C_UNI.div), .HS_POL(C_UNI.hpol), .VS_POL(C_UNI.vpol)
   ) u_uni (.clk(clk), .reset_n(rst_u), .vid(if_u));

   // Expected outputs after the k-th pixel tick since reset (k counts from 0).
   function automatic exp_t model(input int k, input cfg_t c);
      exp_t m;
      int ht, vt, p, p1, h, v;
      ht = c.hres + c.hfp + c.hsync + c.hbp;
      vt = c.vres + c.vfp + c.vsync + c.vbp;
      p  = k % (ht * vt);
      p1 = (k + 1) % (ht * vt);
      h  = p % ht;
      v  = p / ht;
      m.hc  = 12'(p1 % ht);
      m.vc  = 12'(p1 / ht);
      m.hde = (h < c.hres);
      m.vde = (v < c.vres);
      m.hs  = (h >= c.hres + c.hfp && h < c.hres + c.hfp + c.hsync) ? c.hpol : ~c.hpol;
      m.vs  = (v >= c.vres + c.vfp && v < c.vres + c.vfp + c.vsync) ? c.vpol : ~c.vpol;
      m.trig = {21'd0, (v == c.vres && h == 0), (p == 0), (h == 0), 12'(v), 12'(h)};
      return m;
   endfunction

   function automatic exp_t reset_exp(input cfg_t c);
      exp_t m;
      m = '0;
      m.hs = ~c.hpol;
      m.vs = ~c.vpol;
      return m;
   endfunction

   task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic cmp(input string tag, input logic [3:0] pc, input int pc_e,
                      input logic [11:0] hc, input logic [11:0] vc,
                      input logic hde, input logic vde, input logic hs, input logic vs,
                      input logic [47:0] trig, input exp_t e);
      chk({tag, ".pc_ena"},  48'(pc),  48'(pc_e));
      chk({tag, ".h_count"}, 48'(hc),  48'(e.hc));
      chk({tag, ".v_count"}, 48'(vc),  48'(e.vc));
      chk({tag, ".hde"},     48'(hde), 48'(e.hde));
      chk({tag, ".vde"},     48'(vde), 48'(e.vde));
      chk({tag, ".hs"},      48'(hs),  48'(e.hs));
      chk({tag, ".vs"},      48'(vs),  48'(e.vs));
      chk({tag, ".trig"},    trig,     e.trig);
   endtask

   // Per-instance scoreboards: push at the tick edge, pop/compare mid-cycle.
   exp_t q_d[$], q_s[$], q_u[$];
   exp_t cur_d, cur_s, cur_u;
   int   k_d = 0, k_s = 0, k_u = 0;
   int   ph_d = 0, ph_s = 0, ph_u = 0;

   initial forever begin
      @(posedge clk or negedge rst_d);
      if (!rst_d) begin q_d.delete(); k_d = 0; ph_d = 0; end
      else begin
         if (ph_d == 0) begin q_d.push_back(model(k_d, C_DEF)); k_d++; end
         ph_d = (ph_d + 1) % C_DEF.div;
      end
   end
   initial forever begin
      @(posedge clk or negedge rst_s);
      if (!rst_s) begin q_s.delete(); k_s = 0; ph_s = 0; end
      else begin
         if (ph_s == 0) begin q_s.push_back(model(k_s, C_SML)); k_s++; end
         ph_s = (ph_s + 1) % C_SML.div;
      end
   end
   initial forever begin
      @(posedge clk or negedge rst_u);
      if (!rst_u) begin q_u.delete(); k_u = 0; ph_u = 0; end
      else begin
         if (ph_u == 0) begin q_u.push_back(model(k_u, C_UNI)); k_u++; end
         ph_u = (ph_u + 1) % C_UNI.div;
      end
   end

   initial forever begin
      @(negedge clk);
      if (!rst_d) cur_d = reset_exp(C_DEF); else if (q_d.size() > 0) cur_d = q_d.pop_front();
      if (!rst_s) cur_s = reset_exp(C_SML); else if (q_s.size() > 0) cur_s = q_s.pop_front();
      if (!rst_u) cur_u = reset_exp(C_UNI); else if (q_u.size() > 0) cur_u = q_u.pop_front();
      cmp("def", if_d.pc_ena, ph_d, if_d.h_count, if_d.v_count, if_d.hde_out, if_d.vde_out,
          if_d.hs_out, if_d.vs_out, if_d.HV_triggers_out, cur_d);
      cmp("sml", if_s.pc_ena, ph_s, if_s.h_count, if_s.v_count, if_s.hde_out, if_s.vde_out,
          if_s.hs_out, if_s.vs_out, if_s.HV_triggers_out, cur_s);
      cmp("uni", if_u.pc_ena, ph_u, if_u.h_count, if_u.v_count, if_u.hde_out, if_u.vde_out,
          if_u.hs_out, if_u.vs_out, if_u.HV_triggers_out, cur_u);
   end

   typedef struct { int pc; int hc; } ph_vec_t;
   typedef struct { int tick; logic hde; logic hs; logic ls; } line_vec_t;

   ph_vec_t   ph_tab[5];
   line_vec_t ln_tab[8];

   initial begin
      int guard, n, hs_n;
      logic seen_low;

      ph_tab = '{'{1, 1}, '{2, 1}, '{3, 1}, '{0, 1}, '{1, 2}};
      ln_tab = '{'{639, 1'b1, 1'b1, 1'b0}, '{640, 1'b0, 1'b1, 1'b0},
                 '{655, 1'b0, 1'b1, 1'b0}, '{656, 1'b0, 1'b0, 1'b0},
                 '{751, 1'b0, 1'b0, 1'b0}, '{752, 1'b0, 1'b1, 1'b0},
                 '{799, 1'b0, 1'b1, 1'b0}, '{800, 1'b1, 1'b1, 1'b1}};

      repeat (3) @(negedge clk);
      chk("rst.hs_idle", 48'(if_d.hs_out), 48'(1));
      chk("rst.trig",    if_d.HV_triggers_out, 48'd0);
      #2;
      rst_d = 1'b1; rst_s = 1'b1; rst_u = 1'b1;

      // Phase sequence and first tick after release on the default raster.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("phase.pc_ena",  48'(if_d.pc_ena),  48'(ph_tab[i].pc));
         chk("phase.h_count", 48'(if_d.h_count), 48'(ph_tab[i].hc));
         if (i == 0) begin
            chk("first.hde",         48'(if_d.hde_out), 48'(1));
            chk("first.vde",         48'(if_d.vde_out), 48'(1));
            chk("first.frame_start", 48'(if_d.HV_triggers_out[25]), 48'(1));
         end
      end

      // Default line timing at region boundaries.
      for (int i = 0; i < 8; i++) begin
         guard = 0;
         while (k_d < ln_tab[i].tick + 1 && guard < 4000) begin @(negedge clk); guard++; end
         chk("line.reach", 48'(k_d), 48'(ln_tab[i].tick + 1));
         chk("line.hde",   48'(if_d.hde_out), 48'(ln_tab[i].hde));
         chk("line.hs",    48'(if_d.hs_out),  48'(ln_tab[i].hs));
         chk("line.ls",    48'(if_d.HV_triggers_out[24]), 48'(ln_tab[i].ls));
         chk("line.h",     48'(if_d.HV_triggers_out[11:0]), 48'(ln_tab[i].tick % 800));
      end

      // Frame period on the small raster: 12x10 ticks of 4 clk.
      guard = 0;
      while (!if_s.HV_triggers_out[25] && guard < 2000) begin @(negedge clk); guard++; end
      n = 0; seen_low = 1'b0;
      while (n < 2000) begin
         @(negedge clk); n++;
         if (!if_s.HV_triggers_out[25]) seen_low = 1'b1;
         else if (seen_low) break;
      end
      chk("sml.frame_period_clk", 48'(n), 48'(480));

      // Reset in the middle of vertical sync (h=9, v=7 is inside both syncs).
      guard = 0;
      while (!(if_s.HV_triggers_out[11:0] == 12'd9 && if_s.HV_triggers_out[23:12] == 12'd7)
             && guard < 2000) begin @(negedge clk); guard++; end
      chk("rst_mid.in_sync", 48'(if_s.vs_out), 48'(0));
      #2 rst_s = 1'b0;
      #1;
      chk("rst_mid.pc_ena",  48'(if_s.pc_ena),  48'(0));
      chk("rst_mid.h_count", 48'(if_s.h_count), 48'(0));
      chk("rst_mid.v_count", 48'(if_s.v_count), 48'(0));
      chk("rst_mid.hde",     48'(if_s.hde_out), 48'(0));
      chk("rst_mid.hs",      48'(if_s.hs_out),  48'(1));
      chk("rst_mid.vs",      48'(if_s.vs_out),  48'(1));
      chk("rst_mid.trig",    if_s.HV_triggers_out, 48'd0);
      @(negedge clk);
      #2 rst_s = 1'b1;
      @(negedge clk);
      chk("rst_rel.hde",         48'(if_s.hde_out), 48'(1));
      chk("rst_rel.vde",         48'(if_s.vde_out), 48'(1));
      chk("rst_rel.frame_start", 48'(if_s.HV_triggers_out[25]), 48'(1));
      chk("rst_rel.hv",          48'(if_s.HV_triggers_out[23:0]), 48'd0);

      // Unit divider: 12-clk line, hs active-high for two clocks per line.
      guard = 0;
      while (!if_u.HV_triggers_out[24] && guard < 200) begin @(negedge clk); guard++; end
      n = 0; hs_n = 0; seen_low = 1'b0;
      while (n < 200) begin
         @(negedge clk); n++;
         if (if_u.hs_out) hs_n++;
         if (!if_u.HV_triggers_out[24]) seen_low = 1'b1;
         else if (seen_low) break;
      end
      chk("uni.line_period_clk", 48'(n), 48'(12));
      chk("uni.hs_high_clk",     48'(hs_n), 48'(2));
      chk("uni.pc_ena",          48'(if_u.pc_ena), 48'(0));

      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
